dyt_rf_wb_arbiter: RTL and testbench

DYT_RF_WB_ARBITER -- requirements
Module: dyt_rf_wb_arbiter

---
 rtl/dyt_rf_wb_arbiter.sv | 113 +++++++++++
 tb/tb_dyt_rf_wb_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dyt_rf_wb_arbiter.sv
// Register-file writeback arbiter with a pending-write scoreboard.
// The ALU and LSU share one registered write port under round-robin arbitration.
// Issued destinations are marked busy until their write reaches the register file.
module dyt_rf_wb_arbiter #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 32
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [AW-1:0]     alu_sel,
  input  logic [DW-1:0]     alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [AW-1:0]     lsu_sel,
  input  logic [DW-1:0]     lsu_data,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_sel,
  input  logic [AW-1:0]     chk_sel_0,
  input  logic [AW-1:0]     chk_sel_1,
  output logic              hazard,
  output logic [(1<<AW)-1:0] busy_mask,
  output logic              rf_wen,
  output logic [AW-1:0]     rf_w_sel,
  output logic [DW-1:0]     rf_w_data
);

  localparam int unsigned NR = 1 << AW;

  // Records which requester won the most recent handshake.
  typedef enum logic {GrantAlu = 1'b0, GrantLsu = 1'b1} grant_e;

  grant_e          last_q, last_d;
  logic            rf_wen_q, rf_wen_d;
  logic [AW-1:0]   rf_w_sel_q, rf_w_sel_d;
  logic [DW-1:0]   rf_w_data_q, rf_w_data_d;
  logic [NR-1:0]   busy_q, busy_d;

  // Grant: a lone requester always wins; under contention the one not granted last wins.
  always_comb begin
    alu_ready = 1'b0;
    lsu_ready = 1'b0;
    if (n_rst) begin
      if (alu_valid && (!lsu_valid || (last_q == GrantLsu))) begin
        alu_ready = 1'b1;
      end else if (lsu_valid) begin
        lsu_ready = 1'b1;
      end
    end
  end

  // Next state of the write port and the round-robin pointer.
  always_comb begin
    last_d      = last_q;
    rf_wen_d    = 1'b0;
    rf_w_sel_d  = rf_w_sel_q;
    rf_w_data_d = rf_w_data_q;
    if (alu_ready) begin
      last_d      = GrantAlu;
      rf_w_sel_d  = alu_sel;
      rf_w_data_d = alu_data;
      rf_wen_d    = (alu_sel != '0);
    end else if (lsu_ready) begin
      last_d      = GrantLsu;
      rf_w_sel_d  = lsu_sel;
      rf_w_data_d = lsu_data;
      rf_wen_d    = (lsu_sel != '0);
    end
  end

  // Scoreboard: clear on the register-file write, then set on issue so a same-cycle set wins.
  always_comb begin
    busy_d = busy_q;
    if (rf_wen_q) begin
      busy_d[rf_w_sel_q] = 1'b0;
    end
    if (iss_valid && (iss_sel != '0)) begin
      busy_d[iss_sel] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Source hazard check against the current scoreboard; x0 never conflicts.
  always_comb begin
    hazard = n_rst &&
             (((chk_sel_0 != '0) && busy_q[chk_sel_0]) ||
              ((chk_sel_1 != '0) && busy_q[chk_sel_1]));
  end

  // State registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      last_q      <= GrantLsu;
      rf_wen_q    <= 1'b0;
      rf_w_sel_q  <= '0;
      rf_w_data_q <= '0;
      busy_q      <= '0;
    end else begin
      last_q      <= last_d;
      rf_wen_q    <= rf_wen_d;
      rf_w_sel_q  <= rf_w_sel_d;
      rf_w_data_q <= rf_w_data_d;
      busy_q      <= busy_d;
    end
  end

  assign rf_wen    = rf_wen_q;
  assign rf_w_sel  = rf_w_sel_q;
  assign rf_w_data = rf_w_data_q;
  assign busy_mask = busy_q;

endmodule

// File: tb/tb_dyt_rf_wb_arbiter.sv
// Bench for dyt_rf_wb_arbiter: directed scenarios plus randomized traffic,
// all checked against a behavioural model of grants, writes and the scoreboard.
module tb_dyt_rf_wb_arbiter;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned NR = 1 << AW;

  logic clk = 1'b0;
  logic n_rst;
  logic alu_valid, alu_ready, lsu_valid, lsu_ready, iss_valid, hazard, rf_wen;
  logic [AW-1:0] alu_sel, lsu_sel, iss_sel, chk_sel_0, chk_sel_1, rf_w_sel;
  logic [DW-1:0] alu_data, lsu_data, rf_w_data;
  logic [NR-1:0] busy_mask;

  int checks = 0;
  int failures = 0;

  // Model state.
  bit            m_alu_last;   // 1: ALU granted most recently
  bit            m_busy [NR];
  bit            m_wen;
  logic [AW-1:0] m_sel;
  logic [DW-1:0] m_data;

  // Observed grant/hazard from the most recent cycle.
  logic last_ar, last_lr, last_hz;
  int   n_alu, n_lsu;

  always #5 clk = ~clk;

  dyt_rf_wb_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_sel   (alu_sel),
    .alu_data  (alu_data),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_sel   (lsu_sel),
    .lsu_data  (lsu_data),
    .iss_valid (iss_valid),
    .iss_sel   (iss_sel),
    .chk_sel_0 (chk_sel_0),
    .chk_sel_1 (chk_sel_1),
    .hazard    (hazard),
    .busy_mask (busy_mask),
    .rf_wen    (rf_wen),
    .rf_w_sel  (rf_w_sel),
    .rf_w_data (rf_w_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NR-1:0] model_mask();
    logic [NR-1:0] m;
    for (int i = 0; i < NR; i++) m[i] = m_busy[i];
    return m;
  endfunction

  task automatic model_reset();
    m_alu_last = 1'b0;
    for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
    m_wen  = 1'b0;
    m_sel  = '0;
    m_data = '0;
  endtask

  task automatic drive_idle();
    alu_valid = 0; alu_sel = '0; alu_data = '0;
    lsu_valid = 0; lsu_sel = '0; lsu_data = '0;
    iss_valid = 0; iss_sel = '0; chk_sel_0 = '0; chk_sel_1 = '0;
  endtask

  // One clock cycle: drive, check grant/hazard, clock, check registered outputs.
  task automatic cyc(input bit av, input logic [AW-1:0] asel, input logic [DW-1:0] adat,
                     input bit lv, input logic [AW-1:0] lsel, input logic [DW-1:0] ldat,
                     input bit iv, input logic [AW-1:0] isel,
                     input logic [AW-1:0] c0, input logic [AW-1:0] c1);
    bit ea, el, eh;
    alu_valid = av; alu_sel = asel; alu_data = adat;
    lsu_valid = lv; lsu_sel = lsel; lsu_data = ldat;
    iss_valid = iv; iss_sel = isel; chk_sel_0 = c0; chk_sel_1 = c1;
    #1;
    // Lone requester wins; with both, whoever did not win last time.
    ea = av && (!lv || !m_alu_last);
    el = lv && !ea;
    eh = (c0 != 0 && m_busy[c0]) || (c1 != 0 && m_busy[c1]);
    chk("alu_ready", 64'(alu_ready), 64'(ea));
    chk("lsu_ready", 64'(lsu_ready), 64'(el));
    chk("hazard", 64'(hazard), 64'(eh));
    last_ar = alu_ready; last_lr = lsu_ready; last_hz = hazard;
    @(posedge clk);
    if (m_wen) m_busy[m_sel] = 1'b0;
    if (iv && isel != 0) m_busy[isel] = 1'b1;
    m_wen = 1'b0;
    if (ea) begin
      m_alu_last = 1'b1; m_sel = asel; m_data = adat; m_wen = (asel != 0);
    end else if (el) begin
      m_alu_last = 1'b0; m_sel = lsel; m_data = ldat; m_wen = (lsel != 0);
    end
    #1;
    chk("rf_wen", 64'(rf_wen), 64'(m_wen));
    chk("rf_w_sel", 64'(rf_w_sel), 64'(m_sel));
    chk("rf_w_data", 64'(rf_w_data), 64'(m_data));
    chk("busy_mask", 64'(busy_mask), 64'(model_mask()));
  endtask

  task automatic idle_cyc();
    cyc(0, '0, '0, 0, '0, '0, 0, '0, '0, '0);
  endtask

  initial begin
    model_reset();
    drive_idle();
    n_rst = 1'b0;
    // Requests and issues during reset must be ignored.
    alu_valid = 1; lsu_valid = 1; alu_sel = 5'd4; lsu_sel = 5'd8;
    iss_valid = 1; iss_sel = 5'd4; chk_sel_0 = 5'd4;
    #2;
    chk("rst_alu_ready", 64'(alu_ready), 64'd0);
    chk("rst_lsu_ready", 64'(lsu_ready), 64'd0);
    chk("rst_hazard", 64'(hazard), 64'd0);
    @(posedge clk); #1;
    chk("rst_rf_wen", 64'(rf_wen), 64'd0);
    chk("rst_rf_w_sel", 64'(rf_w_sel), 64'd0);
    chk("rst_rf_w_data", 64'(rf_w_data), 64'd0);
    chk("rst_busy_mask", 64'(busy_mask), 64'd0);
    drive_idle();
    @(negedge clk);
    n_rst = 1'b1;
    #1;

    // Contention after reset: ALU first, then LSU.
    cyc(0, '0, '0, 0, '0, '0, 1, 5'd5, '0, '0);
    cyc(0, '0, '0, 0, '0, '0, 1, 5'd6, '0, '0);
    chk("con_busy_set", 64'(busy_mask), 64'h60);
    cyc(1, 5'd5, 32'hAAAA0001, 1, 5'd6, 32'h55550002, 0, '0, '0, '0);
    chk("con_first_alu", 64'(last_ar), 64'd1);
    chk("con_w1", {31'd0, rf_wen, 27'd0, rf_w_sel}, {31'd0, 1'b1, 27'd0, 5'd5});
    cyc(1, 5'd5, 32'hAAAA0001, 1, 5'd6, 32'h55550002, 0, '0, '0, '0);
    chk("con_second_lsu", 64'(last_lr), 64'd1);
    chk("con_w2_data", 64'(rf_w_data), 64'h55550002);
    idle_cyc();
    chk("con_busy_clear", 64'(busy_mask), 64'd0);

    // Write to x0 is granted but dropped.
    cyc(0, '0, '0, 1, 5'd0, 32'hDEADBEEF, 0, '0, '0, '0);
    chk("x0_ready", 64'(last_lr), 64'd1);
    chk("x0_no_wen", 64'(rf_wen), 64'd0);
    chk("x0_busy", 64'(busy_mask), 64'd0);

    // Hazard window on x7.
    cyc(0, '0, '0, 0, '0, '0, 1, 5'd7, '0, '0);
    cyc(0, '0, '0, 0, '0, '0, 0, '0, 5'd7, '0);
    chk("hz_set", 64'(last_hz), 64'd1);
    cyc(1, 5'd7, 32'h00000777, 0, '0, '0, 0, '0, 5'd7, '0);
    chk("hz_hs_cycle", 64'(last_hz), 64'd1);
    cyc(0, '0, '0, 0, '0, '0, 0, '0, 5'd7, '0);
    chk("hz_wen_cycle", 64'(last_hz), 64'd1);
    cyc(0, '0, '0, 0, '0, '0, 0, '0, 5'd7, '0);
    chk("hz_dropped", 64'(last_hz), 64'd0);

    // Set and clear of x9 in the same cycle: the set wins.
    cyc(0, '0, '0, 0, '0, '0, 1, 5'd9, '0, '0);
    cyc(1, 5'd9, 32'h99, 0, '0, '0, 0, '0, '0, '0);
    cyc(0, '0, '0, 0, '0, '0, 1, 5'd9, '0, '0);
    chk("collide_busy9", 64'(busy_mask[9]), 64'd1);

    // Fairness under continuous contention.
    n_alu = 0; n_lsu = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1, 5'(10 + i), $urandom, 1, 5'(20 + i), $urandom, 0, '0, '0, '0);
      n_alu += int'(last_ar);
      n_lsu += int'(last_lr);
    end
    chk("fair_alu", 64'(n_alu), 64'd4);
    chk("fair_lsu", 64'(n_lsu), 64'd4);
    idle_cyc();

    // Reset in the middle of an in-flight write.
    cyc(0, '0, '0, 0, '0, '0, 1, 5'd3, '0, '0);
    cyc(1, 5'd3, 32'h33333333, 0, '0, '0, 0, '0, '0, '0);
    alu_valid = 1; chk_sel_0 = 5'd3;
    #2;
    n_rst = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_wen", 64'(rf_wen), 64'd0);
    chk("mid_rst_busy", 64'(busy_mask), 64'd0);
    chk("mid_rst_sel", 64'(rf_w_sel), 64'd0);
    chk("mid_rst_ready", 64'(alu_ready), 64'd0);
    drive_idle();
    @(negedge clk);
    n_rst = 1'b1;
    #1;
    idle_cyc();
    chk("post_rst_no_wen", 64'(rf_wen), 64'd0);
    idle_cyc();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 9) < 6), 5'($urandom), $urandom,
          ($urandom_range(0, 9) < 6), 5'($urandom), $urandom,
          ($urandom_range(0, 9) < 4), 5'($urandom),
          5'($urandom), 5'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
